// File: rtl/status_event_ctrl_if.sv
// Signal bundle between the event-capture controller and its firmware/event-source side.
interface status_event_ctrl_if;
  logic       enable;
  logic [7:0] event_in;
  logic       ack;
  logic [7:0] status_bus;
  logic       status_valid;
  logic       intr;
  logic [7:0] overflow;
  logic       busy;

  modport master (
    output enable, event_in, ack,
    input  status_bus, status_valid, intr, overflow, busy
  );

  modport slave (
    input  enable, event_in, ack,
    output status_bus, status_valid, intr, overflow, busy
  );
endinterface

// File: rtl/status_event_ctrl.sv
// Latches raw events into firmware-visible snapshots, raises intr per snapshot,
// and waits for an ack followed by a holdoff before presenting the next one.
module status_event_ctrl #(
  parameter logic [7:0]  StickyMask    = 8'hFF,
  parameter int unsigned HoldoffCycles = 16
) (
  input logic                clock,
  input logic                reset_n,
  status_event_ctrl_if.slave bus
);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StWaitAck = 2'd1;
  localparam logic [1:0] StHoldoff = 2'd2;

  localparam logic [7:0] HoldoffInit = 8'(HoldoffCycles);

  logic [1:0] state_q, state_d;
  logic [7:0] prev_q;
  logic [7:0] pending_q, pending_d;
  logic [7:0] snapshot_q, snapshot_d;
  logic [7:0] overflow_q, overflow_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] edge_det;
  logic [7:0] loaded;
  logic       load;
  logic       ack_accept;

  assign edge_det   = bus.event_in & ~prev_q;
  assign load       = (state_q == StIdle) && bus.enable && (pending_q != 8'h00);
  assign ack_accept = (state_q == StWaitAck) && bus.ack;
  assign loaded     = load ? pending_q : 8'h00;

  // A sticky edge in the load cycle survives; level bits just track the input.
  assign pending_d = (StickyMask & ((pending_q & ~loaded) | edge_det)) |
                     (~StickyMask & bus.event_in);

  // A fresh lost event in the ack cycle is kept rather than wiped by the clear.
  assign overflow_d = (ack_accept ? 8'h00 : overflow_q) | (edge_det & pending_q & StickyMask);

  always_comb begin
    state_d    = state_q;
    snapshot_d = snapshot_q;
    cnt_d      = cnt_q;
    case (state_q)
      StIdle: begin
        if (load) begin
          state_d    = StWaitAck;
          snapshot_d = pending_q;
        end
      end
      StWaitAck: begin
        if (bus.ack) begin
          snapshot_d = 8'h00;
          cnt_d      = HoldoffInit;
          state_d    = (HoldoffInit == 8'd0) ? StIdle : StHoldoff;
        end
      end
      StHoldoff: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q <= 8'd1) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      prev_q     <= 8'h00;
      pending_q  <= 8'h00;
      snapshot_q <= 8'h00;
      overflow_q <= 8'h00;
      cnt_q      <= 8'h00;
    end else begin
      state_q    <= state_d;
      prev_q     <= bus.event_in;
      pending_q  <= pending_d;
      snapshot_q <= snapshot_d;
      overflow_q <= overflow_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.status_bus   = snapshot_q;
  assign bus.status_valid = (state_q == StWaitAck);
  assign bus.intr         = (state_q == StWaitAck);
  assign bus.overflow     = overflow_q;
  assign bus.busy         = (state_q != StIdle);

endmodule

// File: tb/tb_status_event_ctrl.sv
// Scoreboard bench for status_event_ctrl: three instances cover default, zero-holdoff
// and level-bit configurations.
module tb_status_event_ctrl;

  logic clock = 1'b0;
  logic reset_n;

  always #5 clock = ~clock;

  status_event_ctrl_if if_a ();
  status_event_ctrl_if if_b ();
  status_event_ctrl_if if_c ();

  status_event_ctrl #(.StickyMask(8'hFF), .HoldoffCycles(16)) u_a (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (if_a)
  );

  status_event_ctrl #(.StickyMask(8'hFF), .HoldoffCycles(0)) u_b (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (if_b)
  );

  status_event_ctrl #(.StickyMask(8'h7F), .HoldoffCycles(4)) u_c (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (if_c)
  );

  int         vectors;
  int         miscompares;
  int         sel;
  logic [7:0] exp_q[$];

  logic [7:0] mon_bus;
  logic [7:0] mon_ovf;
  logic       mon_intr;
  logic       mon_valid;
  logic       mon_busy;

  always_comb begin
    mon_bus   = if_a.status_bus;
    mon_ovf   = if_a.overflow;
    mon_intr  = if_a.intr;
    mon_valid = if_a.status_valid;
    mon_busy  = if_a.busy;
    if (sel == 1) begin
      mon_bus   = if_b.status_bus;
      mon_ovf   = if_b.overflow;
      mon_intr  = if_b.intr;
      mon_valid = if_b.status_valid;
      mon_busy  = if_b.busy;
    end else if (sel == 2) begin
      mon_bus   = if_c.status_bus;
      mon_ovf   = if_c.overflow;
      mon_intr  = if_c.intr;
      mon_valid = if_c.status_valid;
      mon_busy  = if_c.busy;
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic set_events(input logic [7:0] v);
    if (sel == 0) if_a.event_in = v;
    else if (sel == 1) if_b.event_in = v;
    else if_c.event_in = v;
  endtask

  task automatic set_ack(input logic v);
    if (sel == 0) if_a.ack = v;
    else if (sel == 1) if_b.ack = v;
    else if_c.ack = v;
  endtask

  task automatic zero_inputs();
    if_a.event_in = 8'h00; if_a.ack = 1'b0; if_a.enable = 1'b1;
    if_b.event_in = 8'h00; if_b.ack = 1'b0; if_b.enable = 1'b1;
    if_c.event_in = 8'h00; if_c.ack = 1'b0; if_c.enable = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    zero_inputs();
    step(3);
    reset_n = 1'b1;
  endtask

  task automatic pulse(input logic [7:0] v);
    set_events(v);
    step(1);
    set_events(8'h00);
  endtask

  task automatic ack_pulse();
    set_ack(1'b1);
    step(1);
    set_ack(1'b0);
  endtask

  // Wait (bounded) for intr, then pop the scoreboard and compare the presented snapshot.
  task automatic expect_snapshot(input string name, input int budget, output int waited);
    logic [7:0] exp;
    waited = 0;
    while (!mon_intr && waited < budget) begin
      step(1);
      waited++;
    end
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
    vectors++;
    if (mon_intr !== 1'b1 || mon_valid !== 1'b1) begin
      $display("FAIL %s: intr=%b valid=%b after %0d cycles, required 1/1", name, mon_intr,
               mon_valid, waited);
      miscompares++;
    end else if (mon_bus !== exp) begin
      $display("FAIL %s: status_bus=%h required %h", name, mon_bus, exp);
      miscompares++;
    end
  endtask

  task automatic test_reset();
    logic [27:0] outs_a, outs_b, outs_c;
    reset_n = 1'b0;
    zero_inputs();
    step(3);
    for (int pass = 0; pass < 2; pass++) begin
      outs_a = {if_a.status_bus, if_a.status_valid, if_a.intr, if_a.overflow, if_a.busy, 9'h0};
      outs_b = {if_b.status_bus, if_b.status_valid, if_b.intr, if_b.overflow, if_b.busy, 9'h0};
      outs_c = {if_c.status_bus, if_c.status_valid, if_c.intr, if_c.overflow, if_c.busy, 9'h0};
      vectors += 3;
      if (outs_a !== 28'h0) begin
        $display("FAIL reset_a pass%0d: outputs=%h required 0", pass, outs_a); miscompares++;
      end
      if (outs_b !== 28'h0) begin
        $display("FAIL reset_b pass%0d: outputs=%h required 0", pass, outs_b); miscompares++;
      end
      if (outs_c !== 28'h0) begin
        $display("FAIL reset_c pass%0d: outputs=%h required 0", pass, outs_c); miscompares++;
      end
      reset_n = 1'b1;
      step(5);
    end
  endtask

  task automatic test_single_sticky();
    int waited;
    sel = 0;
    do_reset();
    step(8);
    set_events(8'h04);
    step(1);
    set_events(8'h00);
    exp_q.push_back(8'h04);
    vectors++;
    if (mon_intr !== 1'b0 || mon_busy !== 1'b0) begin
      $display("FAIL single_early: intr=%b busy=%b required 0/0", mon_intr, mon_busy);
      miscompares++;
    end
    expect_snapshot("single_sticky", 1, waited);
    step(8);
    vectors++;
    if (mon_intr !== 1'b1 || mon_bus !== 8'h04) begin
      $display("FAIL single_held: intr=%b bus=%h required 1/04", mon_intr, mon_bus);
      miscompares++;
    end
    ack_pulse();
    vectors++;
    if ({mon_intr, mon_valid, mon_bus, mon_busy} !== {1'b0, 1'b0, 8'h00, 1'b1}) begin
      $display("FAIL single_ack: intr=%b valid=%b bus=%h busy=%b required 0/0/00/1",
               mon_intr, mon_valid, mon_bus, mon_busy);
      miscompares++;
    end
    ack_pulse();
    step(14);
    vectors++;
    if (mon_busy !== 1'b1) begin
      $display("FAIL single_holdoff: busy=%b at ack+15 required 1", mon_busy); miscompares++;
    end
    step(1);
    vectors++;
    if (mon_busy !== 1'b0 || mon_intr !== 1'b0) begin
      $display("FAIL single_idle: busy=%b intr=%b at ack+16 required 0/0", mon_busy, mon_intr);
      miscompares++;
    end
  endtask

  task automatic test_overflow();
    int waited;
    sel = 0;
    do_reset();
    step(2);
    pulse(8'h01);
    exp_q.push_back(8'h01);
    expect_snapshot("ovf_first", 1, waited);
    pulse(8'h02);
    step(1);
    pulse(8'h02);
    step(1);
    vectors++;
    if (mon_ovf !== 8'h02 || mon_bus !== 8'h01) begin
      $display("FAIL ovf_set: overflow=%h bus=%h required 02/01", mon_ovf, mon_bus);
      miscompares++;
    end
    exp_q.push_back(8'h02);
    ack_pulse();
    vectors++;
    if (mon_ovf !== 8'h00) begin
      $display("FAIL ovf_clear: overflow=%h required 00", mon_ovf); miscompares++;
    end
    expect_snapshot("ovf_second", 20, waited);
    vectors++;
    if (waited != 17) begin
      $display("FAIL ovf_rearm: intr rose %0d cycles after ack, required 17", waited);
      miscompares++;
    end
    vectors++;
    if (mon_ovf !== 8'h00) begin
      $display("FAIL ovf_stay_clear: overflow=%h required 00", mon_ovf); miscompares++;
    end
    ack_pulse();
    step(17);
  endtask

  task automatic test_back_to_back();
    int waited;
    logic seen;
    sel = 1;
    do_reset();
    step(2);
    pulse(8'h01);
    exp_q.push_back(8'h01);
    expect_snapshot("b2b_first", 1, waited);
    step(3);
    set_events(8'h08);
    set_ack(1'b1);
    step(1);
    set_events(8'h00);
    set_ack(1'b0);
    exp_q.push_back(8'h08);
    vectors++;
    if (mon_intr !== 1'b0 || mon_busy !== 1'b0) begin
      $display("FAIL b2b_gap: intr=%b busy=%b required 0/0", mon_intr, mon_busy);
      miscompares++;
    end
    expect_snapshot("b2b_second", 3, waited);
    vectors++;
    if (waited != 1) begin
      $display("FAIL b2b_gap_len: intr low for %0d cycles, required 1", waited + 1 - 1);
      miscompares++;
    end
    ack_pulse();
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (mon_intr) seen = 1'b1;
      step(1);
    end
    vectors++;
    if (seen !== 1'b0) begin
      $display("FAIL b2b_quiet: intr=%b after final ack, required 0", seen); miscompares++;
    end
  endtask

  task automatic test_enable_level();
    int waited;
    logic seen;
    sel = 2;
    do_reset();
    step(2);
    set_events(8'h80);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (mon_intr || mon_busy) seen = 1'b1;
    end
    vectors++;
    if (seen !== 1'b0) begin
      $display("FAIL en_blocked: intr/busy=%b while enable=0, required 0", seen); miscompares++;
    end
    if_c.enable = 1'b1;
    exp_q.push_back(8'h80);
    expect_snapshot("en_level", 2, waited);
    vectors++;
    if (mon_ovf !== 8'h00) begin
      $display("FAIL en_no_ovf: overflow=%h required 00", mon_ovf); miscompares++;
    end
    set_events(8'h00);
    step(1);
    ack_pulse();
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step(1);
      if (mon_intr) seen = 1'b1;
    end
    vectors++;
    if (seen !== 1'b0 || mon_busy !== 1'b0 || mon_bus !== 8'h00) begin
      $display("FAIL en_no_repeat: intr_seen=%b busy=%b bus=%h required 0/0/00", seen,
               mon_busy, mon_bus);
      miscompares++;
    end
  endtask

  task automatic test_reset_mid();
    int waited;
    logic seen;
    sel = 0;
    do_reset();
    step(2);
    pulse(8'h01);
    exp_q.push_back(8'h01);
    expect_snapshot("mid_first", 1, waited);
    pulse(8'h02);
    step(1);
    pulse(8'h02);
    step(1);
    vectors++;
    if (mon_ovf !== 8'h02) begin
      $display("FAIL mid_ovf: overflow=%h required 02", mon_ovf); miscompares++;
    end
    reset_n = 1'b0;
    step(1);
    vectors++;
    if ({mon_bus, mon_intr, mon_valid, mon_ovf, mon_busy} !== 19'h0) begin
      $display("FAIL mid_reset: bus=%h intr=%b valid=%b ovf=%h busy=%b required all 0",
               mon_bus, mon_intr, mon_valid, mon_ovf, mon_busy);
      miscompares++;
    end
    reset_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (mon_intr || mon_busy) seen = 1'b1;
    end
    vectors++;
    if (seen !== 1'b0) begin
      $display("FAIL mid_no_replay: intr/busy=%b after release, required 0", seen);
      miscompares++;
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    sel         = 0;
    reset_n     = 1'b0;
    zero_inputs();
    test_reset();
    test_single_sticky();
    test_overflow();
    test_back_to_back();
    test_enable_level();
    test_reset_mid();
    vectors++;
    if (exp_q.size() != 0) begin
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
      miscompares++;
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
